// File: rtl/reg_status_file_pkg.sv
// ---------------------------------------------------------------------------
// reg_status_file_pkg
//   Shared constants for the architectural register file / rename table:
//   default ROB tag width and data width, register index width, register
//   count and the hard-wired x0 index.
//   Optional feature macro used by the files of this block:
//     REG_COMMIT_BYPASS_EN - forward a same-cycle commit into the lookups.
// ---------------------------------------------------------------------------
package reg_status_file_pkg;

  localparam int ROB_W_DFLT = 4;
  localparam int XLEN_DFLT  = 32;
  localparam int REG_IDX_W  = 5;
  localparam int NUM_REGS   = 1 << REG_IDX_W;

  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

endpackage : reg_status_file_pkg

// File: rtl/reg_status_lookup.sv
// ---------------------------------------------------------------------------
// reg_status_lookup
//   One combinational operand read port of the register status file.
//   Returns the committed value (rd_rdy=1) or the producing ROB tag
//   zero-extended (rd_rdy=0). x0 always reads 0, ready.
//   Macro REG_COMMIT_BYPASS_EN adds forwarding of a same-cycle commit whose
//   tag matches the current producer of the looked-up register.
// Ports:
//   idx       in  register index to look up
//   val_arr   in  committed values of all registers
//   busy_arr  in  rename-pending flags of all registers
//   tag_arr   in  producer ROB tags of all registers
//   byp_en    in  (bypass build) a commit really happens this cycle
//   cm_rd     in  (bypass build) commit destination
//   cm_val    in  (bypass build) commit value
//   cm_name   in  (bypass build) commit ROB tag
//   rd_val    out value or zero-extended tag
//   rd_rdy    out 1 = rd_val is a value
// ---------------------------------------------------------------------------
module reg_status_lookup
  import reg_status_file_pkg::*;
#(
  parameter int ROB_W = ROB_W_DFLT,
  parameter int XLEN  = XLEN_DFLT
) (
  input  logic [REG_IDX_W-1:0]           idx,
  input  logic [NUM_REGS-1:0][XLEN-1:0]  val_arr,
  input  logic [NUM_REGS-1:0]            busy_arr,
  input  logic [NUM_REGS-1:0][ROB_W-1:0] tag_arr,
`ifdef REG_COMMIT_BYPASS_EN
  input  logic                           byp_en,
  input  logic [REG_IDX_W-1:0]           cm_rd,
  input  logic [XLEN-1:0]                cm_val,
  input  logic [ROB_W-1:0]               cm_name,
`endif
  output logic [XLEN-1:0]                rd_val,
  output logic                           rd_rdy
);

  // NOTE: every output gets a default first so no path through the block
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_val = '0;
    rd_rdy = 1'b1;
    if (idx != REG_X0) begin
      if (busy_arr[idx]) begin
        rd_val[ROB_W-1:0] = tag_arr[idx];
        rd_rdy            = 1'b0;
      end else begin
        rd_val = val_arr[idx];
      end
`ifdef REG_COMMIT_BYPASS_EN
      // Only the commit from the current producer may resolve the operand;
      // a stale commit leaves the younger tag in place.
      if (byp_en && (cm_rd == idx) && busy_arr[idx] && (tag_arr[idx] == cm_name)) begin
        rd_val = cm_val;
        rd_rdy = 1'b1;
      end
`endif
    end
  end

endmodule : reg_status_lookup

// File: rtl/reg_status_file.sv
// ---------------------------------------------------------------------------
// reg_status_file
//   Architectural register file plus rename/busy table. Serves two
//   combinational operand lookups, records the producer ROB tag of rd on
//   issue, retires values on ROB commit and drops all renames on flush.
//   Macro REG_COMMIT_BYPASS_EN: lookups forward a matching same-cycle commit.
// Ports:
//   clk, rst            clock; asynchronous active-low reset
//   rdy                 global enable, all state holds when 0
//   REG_rs1/REG_rs2     lookup indices
//   REG_rs1_val/_rdy    operand 1 value-or-tag and ready flag
//   REG_rs2_val/_rdy    operand 2 value-or-tag and ready flag
//   REG_sgn, REG_rd     issue renames REG_rd to ROB_name
//   ROB_name            tag of the issuing instruction
//   CM_sgn, CM_rd       ROB commit of a register-writing entry
//   CM_val, CM_name     commit value and committing tag
//   FLUSH_sgn           drop every pending rename
// ---------------------------------------------------------------------------
module reg_status_file
  import reg_status_file_pkg::*;
#(
  parameter int ROB_W = ROB_W_DFLT,
  parameter int XLEN  = XLEN_DFLT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [REG_IDX_W-1:0] REG_rs1,
  input  logic [REG_IDX_W-1:0] REG_rs2,
  output logic [XLEN-1:0]      REG_rs1_val,
  output logic [XLEN-1:0]      REG_rs2_val,
  output logic                 REG_rs1_rdy,
  output logic                 REG_rs2_rdy,
  input  logic                 REG_sgn,
  input  logic [REG_IDX_W-1:0] REG_rd,
  input  logic [ROB_W-1:0]     ROB_name,
  input  logic                 CM_sgn,
  input  logic [REG_IDX_W-1:0] CM_rd,
  input  logic [XLEN-1:0]      CM_val,
  input  logic [ROB_W-1:0]     CM_name,
  input  logic                 FLUSH_sgn
);

  if (ROB_W > XLEN) begin : g_bad_cfg
    $error("reg_status_file: ROB_W must not exceed XLEN");
  end

  logic [NUM_REGS-1:0][XLEN-1:0]  val_q,  val_d;
  logic [NUM_REGS-1:0]            busy_q, busy_d;
  logic [NUM_REGS-1:0][ROB_W-1:0] tag_q,  tag_d;

  always_comb begin
    val_d  = val_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (rdy) begin
      if (CM_sgn && (CM_rd != REG_X0)) begin
        val_d[CM_rd] = CM_val;
        // A mismatching tag means a younger producer owns the register.
        if (busy_q[CM_rd] && (tag_q[CM_rd] == CM_name)) begin
          busy_d[CM_rd] = 1'b0;
        end
      end
      // Applied after the commit so a same-register issue wins busy/tag.
      if (FLUSH_sgn) begin
        busy_d = '0;
      end else if (REG_sgn && (REG_rd != REG_X0)) begin
        busy_d[REG_rd] = 1'b1;
        tag_d[REG_rd]  = ROB_name;
      end
    end
    val_d[REG_X0]  = '0;
    busy_d[REG_X0] = 1'b0;
    tag_d[REG_X0]  = '0;
  end

  // NOTE: the storage is reset on purpose: lookups must read value 0,
  // ready, for every register straight after reset, including entries that
  // were busy before it. Flops use non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q  <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      val_q  <= val_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

`ifdef REG_COMMIT_BYPASS_EN
  logic byp_en;
  assign byp_en = rdy & CM_sgn;
`endif

  reg_status_lookup #(.ROB_W(ROB_W), .XLEN(XLEN)) u_lookup_rs1 (
    .idx      (REG_rs1),
    .val_arr  (val_q),
    .busy_arr (busy_q),
    .tag_arr  (tag_q),
`ifdef REG_COMMIT_BYPASS_EN
    .byp_en   (byp_en),
    .cm_rd    (CM_rd),
    .cm_val   (CM_val),
    .cm_name  (CM_name),
`endif
    .rd_val   (REG_rs1_val),
    .rd_rdy   (REG_rs1_rdy)
  );

  reg_status_lookup #(.ROB_W(ROB_W), .XLEN(XLEN)) u_lookup_rs2 (
    .idx      (REG_rs2),
    .val_arr  (val_q),
    .busy_arr (busy_q),
    .tag_arr  (tag_q),
`ifdef REG_COMMIT_BYPASS_EN
    .byp_en   (byp_en),
    .cm_rd    (CM_rd),
    .cm_val   (CM_val),
    .cm_name  (CM_name),
`endif
    .rd_val   (REG_rs2_val),
    .rd_rdy   (REG_rs2_rdy)
  );

endmodule : reg_status_file

// File: doc/reg_status_file.md
Name: reg_status_file

Overview:
- Architectural register file plus rename/busy table; the responder on the issue-stage register interface.
- Answers combinational operand lookups for rs1/rs2 with either the committed value or the producing ROB tag.
- Records the new producer tag for rd on issue, and retires values on ROB commit.
- A mispredict flush drops all pending renames.

Parameters:
ROB_W, 4, ROB tag width; must match the `ROBID range.
XLEN, 32, register value width.

Ports:
clk  in  1  clock, all state updates on the rising edge
rst  in  1  asynchronous reset, active-low: asserted when 0
rdy  in  1  global enable; when 0, all state holds and lookups stay valid
REG_rs1  in  5  lookup index, operand 1
REG_rs2  in  5  lookup index, operand 2
REG_rs1_val  out  XLEN  value if ready, else producing ROB tag zero-extended
REG_rs2_val  out  XLEN  same for operand 2
REG_rs1_rdy  out  1  1 = value valid; 0 = the _val port carries a tag
REG_rs2_rdy  out  1  same for operand 2
REG_sgn  in  1  issue allocates rd this cycle
REG_rd  in  5  destination register being renamed
ROB_name  in  ROB_W  ROB tag assigned to the issuing instruction
CM_sgn  in  1  ROB commits a register-writing entry
CM_rd  in  5  commit destination
CM_val  in  XLEN  commit value
CM_name  in  ROB_W  tag of the committing entry
FLUSH_sgn  in  1  mispredict or clear; drop all renames

Behaviour:
- State per register i in 1..31: val[i] (XLEN), busy[i] (1 bit), tag[i] (ROB_W). x0 is hard-wired: val 0, never busy.
- Reset (rst=0, asynchronous): all val=0, busy=0, tag=0. The lookup outputs then read val 0, rdy 1. No other outputs exist.
- Lookup, combinational, zero latency, reflecting the state before the current edge:
  - busy=0 -> val[i], rdy=1.
  - busy=1 -> {0, tag[i]}, rdy=0.
  - x0 -> 0, rdy=1.
- Commit, at the edge, rdy=1, CM_sgn=1, CM_rd!=0:
  - val[CM_rd] <= CM_val.
  - If busy[CM_rd] and tag[CM_rd]==CM_name, clear busy. Otherwise busy and tag are untouched, because a younger producer owns the register.
- Issue, at the edge, rdy=1, REG_sgn=1, REG_rd!=0: busy[REG_rd] <= 1, tag[REG_rd] <= ROB_name.
- Simultaneous issue and commit to the same rd: the value is written and the register ends busy=1 with tag=ROB_name. Issue wins for busy/tag.
- Issue whose rd equals its own rs1 or rs2: the lookup returns the old mapping. The new tag is visible from the next cycle.
- Flush, at the edge, FLUSH_sgn=1:
  - All busy <= 0 and any same-cycle issue is ignored.
  - A same-cycle commit still writes val. Commits are architecturally older than the flush point.
- rdy=0: no state changes; flush, issue and commit are all ignored.
- ROB_W > XLEN is illegal.

Optional Feature:
Macro REG_COMMIT_BYPASS_EN.
- Defined: lookups forward a same-cycle commit. If CM_sgn=1, CM_rd==lookup index !=0, busy=1 and tag==CM_name, the lookup returns CM_val with rdy=1. This removes a one-cycle operand-wait bubble.
- Undefined: lookups read registered state only. The issued operand carries the tag, and the RS must catch the value from the CDB.

Decomposition:
- Shared defines file: `ROBID width, XLEN, reg index width (5), the x0 constant.
- One natural sub-module, reg_status_lookup: one combinational read port with optional bypass, instantiated twice for rs1 and rs2.
- The top module owns the storage arrays and the update logic.

Test Plan:
- Reset with rst=0 mid-run, then release -> every register reads val 0, rdy 1, even entries busy before reset.
- Issue REG_rd=5, ROB_name=3 -> next cycle REG_rs1=5 reads val 0x3, rdy 0. Commit CM_rd=5, CM_name=3, CM_val=0xDEAD -> next cycle reads 0xDEAD, rdy 1.
- Stale commit: issue x7 tag 2, then issue x7 tag 9, then commit x7 tag 2 val 0x11 -> x7 stays busy, reads 0x9, rdy 0. Commit tag 9 val 0x22 -> reads 0x22, rdy 1.
- Same-edge issue x4 tag 6 and commit x4 tag 1 val 0x55 (x4 previously busy tag 1) -> x4 busy, tag 6. After flush -> x4 reads 0x55, rdy 1.
- Flush with three busy regs and a simultaneous issue x9 -> all read rdy 1; x9 is not busy. With rdy=0 the same stimulus changes nothing.
- Bypass: x10 busy tag 4 and commit x10 tag 4 val 0x77 in the same cycle as lookup REG_rs2=10 -> with REG_COMMIT_BYPASS_EN, 0x77 rdy 1; without it, 0x4 rdy 0. Writes to x0 -> reads 0 always.
